// File: rtl/pattern_detect_ctrl.sv
// Serial 4-bit pattern detector with a config handshake and match target.
// Moore FSM: IDLE -> LOAD -> RUN -> (DONE) -> IDLE.
module pattern_detect_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_pattern,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_target,
    input  logic       din_valid,
    input  logic       din,
    input  logic       abort,
    output logic       busy,
    output logic       match,
    output logic [7:0] match_count,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pat_q, pat_d;
    logic       ovl_q, ovl_d;
    logic [7:0] tgt_q, tgt_d;
    logic [3:0] win_q, win_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] cnt_q, cnt_d;
    logic       match_q, match_d;

    logic [3:0] win_nx;
    logic [2:0] fill_nx;
    logic [7:0] cnt_inc;
    logic       hit;

    assign cfg_ready   = (state_q == S_IDLE);
    assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match       = match_q;
    assign match_count = cnt_q;

    // Next-state, capture, shift window and match bookkeeping
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        win_nx  = {win_q[2:0], din};
        fill_nx = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
        cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        hit     = (fill_nx == 3'd4) && (win_nx == pat_q);

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pat_d   = cfg_pattern;
                    ovl_d   = cfg_overlap;
                    tgt_d   = cfg_target;
                    cnt_d   = 8'd0;
                    win_d   = 4'd0;
                    fill_d  = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    // abort wins over a same-cycle bit, which is dropped
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    win_d = win_nx;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        fill_d  = ovl_q ? 3'd4 : 3'd0;
                        if ((tgt_q != 8'd0) && (cnt_inc == tgt_q)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        fill_d = fill_nx;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= 4'd0;
            ovl_q   <= 1'b0;
            tgt_q   <= 8'd0;
            win_q   <= 4'd0;
            fill_q  <= 3'd0;
            cnt_q   <= 8'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl: directed bit streams,
// expected match/done pulses queued at stimulus time, checked by a monitor.
module tb_pattern_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_pattern = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = 8'd0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       done;

    int errors = 0;
    int checks = 0;

    // {match, done, match_count}
    logic [9:0] exp_q [$];

    pattern_detect_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .din_valid  (din_valid),
        .din        (din),
        .abort      (abort),
        .busy       (busy),
        .match      (match),
        .match_count(match_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: whenever a pulse is presented, pop and compare
    always @(negedge clk) begin
        if (!reset && (match || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got match=%0b done=%0b cnt=%0d, expected no pulse",
                         match, done, match_count);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({match, done, match_count} !== e) begin
                    errors++;
                    $display("FAIL pulse: got match=%0b done=%0b cnt=%0d, expected match=%0b done=%0b cnt=%0d",
                             match, done, match_count, e[9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic em, input logic ed, input logic [7:0] c);
        din_valid = 1'b1;
        din = b;
        if (em || ed) exp_q.push_back({em, ed, c});
        cyc();
        din_valid = 1'b0;
    endtask

    task automatic configure(input logic [3:0] p, input logic ov, input logic [7:0] t);
        chk("cfg_ready_idle", {7'd0, cfg_ready}, 8'd1);
        cfg_pattern = p;
        cfg_overlap = ov;
        cfg_target  = t;
        cfg_valid   = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        chk("busy_load", {7'd0, busy}, 8'd1);
        chk("cnt_cleared", match_count, 8'd0);
        cyc();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_cfg_ready", {7'd0, cfg_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_match", {7'd0, match}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_cnt", match_count, 8'd0);

        // Abort in IDLE has no effect
        do_abort();
        chk("abort_idle", {7'd0, cfg_ready}, 8'd1);

        // Non-overlap, 1001 over 1,0,0,1,0,0,1 with idle gaps
        configure(4'b1001, 1'b0, 8'd0);
        send_bit(1, 0, 0, 0);
        cyc();
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        cyc();
        send_bit(1, 1, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(1, 0, 0, 1);
        cyc();
        chk("nov_cnt", match_count, 8'd1);
        do_abort();
        chk("nov_abort_idle", {7'd0, cfg_ready}, 8'd1);
        chk("nov_cnt_hold", match_count, 8'd1);

        // Overlap, same stream: two matches
        configure(4'b1001, 1'b1, 8'd0);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(1, 1, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(1, 1, 0, 2);
        do_abort();
        chk("ov_cnt", match_count, 8'd2);
        chk("ov_busy", {7'd0, busy}, 8'd0);

        // Overlap with target 2: done after 7th bit, rest ignored
        configure(4'b1001, 1'b1, 8'd2);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(1, 1, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(1, 1, 1, 2);
        chk("tgt_done_state", {7'd0, done}, 8'd1);
        chk("tgt_done_busy", {7'd0, busy}, 8'd0);
        send_bit(0, 0, 0, 2);
        chk("tgt_idle", {7'd0, cfg_ready}, 8'd1);
        send_bit(0, 0, 0, 2);
        send_bit(1, 0, 0, 2);
        chk("tgt_cnt_hold", match_count, 8'd2);

        // Target 1 boundary in non-overlap mode
        configure(4'b1001, 1'b0, 8'd1);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(1, 1, 1, 1);
        cyc();
        chk("tgt1_idle", {7'd0, cfg_ready}, 8'd1);

        // Abort together with the completing bit
        configure(4'b1001, 1'b0, 8'd0);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        abort = 1'b1;
        send_bit(1, 0, 0, 0);
        abort = 1'b0;
        chk("ab_idle", {7'd0, cfg_ready}, 8'd1);
        chk("ab_match", {7'd0, match}, 8'd0);
        chk("ab_cnt", match_count, 8'd0);

        // cfg_valid during RUN is ignored
        configure(4'b1001, 1'b0, 8'd0);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        cfg_pattern = 4'b0110;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        chk("cfgrun_busy", {7'd0, busy}, 8'd1);
        send_bit(0, 0, 0, 0);
        send_bit(1, 1, 0, 1);
        send_bit(0, 0, 0, 1);
        send_bit(1, 0, 0, 1);
        send_bit(1, 0, 0, 1);
        send_bit(0, 0, 0, 1);
        chk("cfgrun_cnt", match_count, 8'd1);
        do_abort();

        // Abort during LOAD has no effect
        cfg_pattern = 4'b1001;
        cfg_overlap = 1'b0;
        cfg_target = 8'd0;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        do_abort();
        chk("load_abort_run", {7'd0, busy}, 8'd1);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(1, 1, 0, 1);
        do_abort();

        // Reset mid-run
        configure(4'b1001, 1'b0, 8'd0);
        send_bit(1, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        send_bit(0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mrst_cfg_ready", {7'd0, cfg_ready}, 8'd1);
        chk("mrst_busy", {7'd0, busy}, 8'd0);
        chk("mrst_match", {7'd0, match}, 8'd0);
        chk("mrst_done", {7'd0, done}, 8'd0);
        chk("mrst_cnt", match_count, 8'd0);
        send_bit(1, 0, 0, 0);
        cyc();
        chk("mrst_no_match_cnt", match_count, 8'd0);

        cyc();
        chk("sb_empty", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: cfg_valid  input  1  configuration request.
REQ-004 SHALL have: cfg_ready  output  1  configuration accepted when cfg_valid & cfg_ready.
REQ-005 SHALL have: cfg_pattern  input  4  pattern; bit 3 is the first serial bit.
REQ-006 SHALL have: cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-007 SHALL have: cfg_target  input  8  number of matches to run; 0 = run until abort.
REQ-008 SHALL have: din_valid  input  1  serial bit qualifier.
REQ-009 SHALL have: din  input  1  serial data bit.
REQ-010 SHALL have: abort  input  1  terminate a run.
REQ-011 SHALL have: busy  output  1  high in LOAD and RUN.
REQ-012 SHALL have: match  output  1  one-cycle registered match pulse.
REQ-013 SHALL have: match_count  output  8  matches in the current or last run.
REQ-014 SHALL have: done  output  1  one-cycle pulse when the target is reached.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE; all outputs registered or decoded from state (Moore).
REQ-016 cfg_ready SHALL be 1 only in IDLE; cfg_valid in any other state SHALL be ignored.
REQ-017 IDLE: on cfg_valid & cfg_ready, capture pattern/overlap/target into internal registers, clear match_count, clear the shift window and fill counter, and go to LOAD.
REQ-018 LOAD: SHALL last exactly 1 cycle, then go to RUN; din_valid in LOAD SHALL be ignored.
REQ-019 RUN: on din_valid, shift din into a 4-bit window (new bit at LSB) and increment a fill counter saturating at 4.
REQ-020 Match condition: fill counter (including the new bit) = 4 and the updated window = captured pattern.
REQ-021 On a match, match SHALL be 1 for exactly the cycle after the sampling edge, and match_count SHALL increment (saturating at 255).
REQ-022 Non-overlap mode: on a match, the fill counter SHALL reset to 0, so the next match needs 4 new bits.
REQ-023 Overlap mode: on a match, the fill counter SHALL remain at 4.
REQ-024 When cfg_target != 0 and match_count reaches cfg_target, the FSM SHALL go to DONE at the same edge; further bits SHALL be ignored.
REQ-025 DONE: SHALL last 1 cycle with done = 1, then go to IDLE; match_count SHALL hold until the next accepted configuration.
REQ-026 abort in RUN SHALL force IDLE at the next edge without asserting done; match_count SHALL hold.
REQ-027 abort together with din_valid SHALL let abort win; the bit SHALL be discarded and no match SHALL be flagged.
REQ-028 abort outside RUN SHALL have no effect.
REQ-029 din_valid = 0 cycles SHALL NOT alter the window, fill counter or match_count.

Reset
REQ-030 reset SHALL set state = IDLE, cfg_ready = 1, busy = 0, match = 0, done = 0, match_count = 0, window = 0, fill counter = 0, and all captured config = 0.
REQ-031 reset SHALL take priority over every other input in any state, including mid-run.

Verification
REQ-032 Pattern 1001, overlap = 0, target = 0, bits 1,0,0,1,0,0,1 -> one match pulse (after 4th bit), match_count = 1.
REQ-033 Same bits with overlap = 1 -> two match pulses (after 4th and 7th bits), match_count = 2.
REQ-034 Pattern 1001, overlap = 1, target = 2, bits 1,0,0,1,0,0,1,0,0,1 -> done pulse on the cycle after the 7th bit, then IDLE, match_count = 2, 10th bit ignored.
REQ-035 Abort asserted with din_valid on the completing 4th bit of 1001 -> no match, IDLE next cycle, match_count = 0.
REQ-036 cfg_valid pulsed during RUN with a different pattern -> ignored; detection keeps using the original pattern.
REQ-037 reset after 3 bits of 1001 in RUN -> all outputs at reset values next cycle; a new configuration is needed before further matches.
